mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle control FSM: consumes opcode/func from the datapath, drives its control inputs
//  (PCWr, IRWr, beq, jal, jr, ALUOP, EXTOP, WRSel, BSel, WDSel, RFWr, DMWr).
//  Handshakes with a variable-latency data memory via mem_ready; counts retired instructions.
//  Supported: addu subu jr nop(sll 0) ori lui lw sw beq jal.
// PARAMETERS
//  CNT_W         32  width of retired-instruction counter instr_cnt
//  ILLEGAL_TRAP  1   1: unknown instr -> S_HALT forever; 0: unknown instr retired as nop
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  opcode     in   6      IR[31:26]; valid from S_DECODE onward
//  func       in   6      IR[5:0]
//  zero       in   1      ALU ZERO (datapath resolves branch in NPC; monitored only)
//  mem_ready  in   1      DM access complete this cycle
//  PCWr IRWr  out  1      PC / IR write enables
//  beq jal jr out  1      NPC select strobes
//  ALUOP      out  3      000 ADD, 001 SUB, 010 OR, 011 LUI(imm<<16)
//  EXTOP      out  1      0 zero-ext, 1 sign-ext
//  WRSel      out  2      00 rt, 01 rd, 10 $31
//  BSel       out  1      0 RD2, 1 EXT
//  WDSel      out  2      00 ALU OUT, 01 Memoryout, 10 PC+4
//  RFWr DMWr  out  1      GRF / DM write enables
//  instr_done out  1      1-cycle pulse, coincident with PCWr
//  instr_cnt  out  CNT_W  retired count, wraps 2^CNT_W-1 -> 0
//  illegal    out  1      sticky: unknown opcode/func decoded
//  halted     out  1      high in S_HALT
// BEHAVIOUR
//  Reset (reset==0, async): state=S_RST, op_q/fn_q=0, instr_cnt=0, illegal=0; all outputs 0.
//   Asserting mid-instruction drops DMWr/RFWr/PCWr immediately; in-flight sw aborted.
//  S_RST -> S_FETCH on first clk after release. Outputs: Moore from state + op_q/fn_q (latched
//   in S_DECODE, so output timing never depends on live opcode after decode).
//  S_FETCH : IRWr=1 -> S_DECODE (1 cycle).
//  S_DECODE: latch op_q/fn_q. jal -> S_WB; nop -> retire here (PCWr=1) -> S_FETCH;
//   unknown -> illegal<=1, then S_HALT if ILLEGAL_TRAP else retire as nop; others -> S_EXE.
//  S_EXE   : ALUOP/BSel/EXTOP per instr. addu ADD,BSel0; subu SUB,BSel0; ori OR,BSel1,EXTOP0;
//   lui LUI,BSel1; lw/sw ADD,BSel1,EXTOP1 -> S_MEM. beq: SUB,BSel0,beq=1,PCWr=1 -> S_FETCH.
//   jr: jr=1,PCWr=1 -> S_FETCH. ALU ops -> S_WB.
//  S_MEM   : ALUOP/BSel/EXTOP held. sw: DMWr=1 every cycle until mem_ready; on mem_ready
//   PCWr=1 (retire) -> S_FETCH. lw: wait for mem_ready -> S_WB. No timeout.
//  S_WB    : RFWr=1, PCWr=1. R-type WRSel01/WDSel00; ori,lui WRSel00/WDSel00;
//   lw WRSel00/WDSel01; jal WRSel10/WDSel10,jal=1. -> S_FETCH.
//  S_HALT  : all enables 0, halted=1; exit only by reset.
//  Retire: exactly one PCWr per instruction, in its final cycle; instr_done=PCWr;
//   instr_cnt+1 on that edge. CPI: nop 2, beq/jr 3, jal 3, ALU 4, sw 4+wait, lw 5+wait.
//  mem_ready outside S_MEM ignored. IRWr and PCWr never both 1.
// STRUCTURE
//  Header ctrl_defs.vh: opcode/func codes (R 000000, ori 001101, lui 001111, lw 100011,
//   sw 101011, beq 000100, jal 000011; addu 100001, subu 100011, jr 001000),
//   ALUOP/WRSel/WDSel encodings, state codes.
//  Sub-module ctrl_decode: combinational op/fn -> one-hot instr class + illegal.
//  mc_controller: state reg, op_q/fn_q, counter, output decode.
// TESTING
//  1 reset low 3 cyc, release; addu -> FETCH,DECODE,EXE,WB; WB: RFWr=1,WRSel=01,PCWr=1, cnt=1.
//  2 lw, mem_ready low 3 cyc in S_MEM -> S_MEM held 4 cyc, RFWr=0 there; WB WDSel=01.
//  3 sw, mem_ready at 2nd S_MEM cyc -> DMWr=1 both cycles, PCWr only 2nd; reset low mid-MEM
//    -> DMWr=0 same cycle, cnt=0.
//  4 beq / jal / jr: PCWr in EXE with beq=1; jal WB WRSel=10,WDSel=10; jr=1 in EXE; 3 cyc each.
//  5 opcode 111111: illegal=1, halted=1 (TRAP=1); TRAP=0 -> retired in DECODE, cnt+1.
//  6 preload instr_cnt 2^CNT_W-1, retire nop -> cnt wraps to 0; instr_done 1-cycle pulse.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared encodings for the multi-cycle control FSM.
//   Opcode/func codes of the supported instructions, datapath mux encodings,
//   FSM state type and the one-hot instruction class produced by the decoder.
package mc_controller_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type func codes (IR[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    // ALU operation select
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    // Register-file write address select
    localparam logic [1:0] WR_RT    = 2'b00;
    localparam logic [1:0] WR_RD    = 2'b01;
    localparam logic [1:0] WR_RA    = 2'b10;

    // Register-file write data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    typedef enum logic [2:0] {
        StRst    = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExe    = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_t;

    // At most one bit set; all-zero means the instruction is not supported.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic nop;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
    } instr_cls_t;

endpackage

// File: rtl/mc_controller_decode.sv
// mc_controller_decode: combinational instruction classifier.
//   opcode  in  6   instruction opcode
//   func    in  6   R-type function field
//   cls     out     one-hot instruction class
//   illegal out 1   opcode/func combination not supported
module mc_controller_decode
    import mc_controller_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    output instr_cls_t  cls,
    output logic        illegal
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (func)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    FN_SLL:  cls.nop  = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: ;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS-subset control FSM.
//   clk, reset (async, active low)
//   opcode/func : instruction fields from IR (valid from decode onward)
//   zero        : ALU zero flag (branch resolved in datapath; not used here)
//   mem_ready   : data memory access completes this cycle
//   PCWr IRWr beq jal jr ALUOP EXTOP WRSel BSel WDSel RFWr DMWr : datapath controls
//   instr_done  : retire pulse (== PCWr), instr_cnt : retired instruction count
//   illegal     : sticky unsupported-instruction flag, halted : in halt state
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             beq,
    output logic             jal,
    output logic             jr,
    output logic [2:0]       ALUOP,
    output logic             EXTOP,
    output logic [1:0]       WRSel,
    output logic             BSel,
    output logic [1:0]       WDSel,
    output logic             RFWr,
    output logic             DMWr,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal,
    output logic             halted
);

    state_t           state_q, state_d;
    logic [5:0]       op_q, fn_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0]       dec_op, dec_fn;
    instr_cls_t       cls;
    logic             dec_illegal;
    logic             unused_zero;

    assign unused_zero = zero;

    // Decode sees the live IR only during decode; afterwards the latched copy,
    // so later outputs cannot glitch if the IR changes.
    assign dec_op = (state_q == StDecode) ? opcode : op_q;
    assign dec_fn = (state_q == StDecode) ? func   : fn_q;

    mc_controller_decode u_decode (
        .opcode  (dec_op),
        .func    (dec_fn),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        beq     = 1'b0;
        jal     = 1'b0;
        jr      = 1'b0;
        ALUOP   = ALU_ADD;
        EXTOP   = 1'b0;
        WRSel   = WR_RT;
        BSel    = 1'b0;
        WDSel   = WD_ALU;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        halted  = 1'b0;

        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                IRWr    = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (dec_illegal) begin
                    if (ILLEGAL_TRAP) begin
                        state_d = StHalt;
                    end else begin
                        PCWr    = 1'b1;
                        state_d = StFetch;
                    end
                end else if (cls.nop) begin
                    PCWr    = 1'b1;
                    state_d = StFetch;
                end else if (cls.jal) begin
                    state_d = StWb;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                if (cls.beq) begin
                    beq     = 1'b1;
                    PCWr    = 1'b1;
                    state_d = StFetch;
                end else if (cls.jr) begin
                    jr      = 1'b1;
                    PCWr    = 1'b1;
                    state_d = StFetch;
                end else if (cls.lw || cls.sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (cls.sw) begin
                    // Write strobe stays up until memory accepts it.
                    DMWr = 1'b1;
                    if (mem_ready) begin
                        PCWr    = 1'b1;
                        state_d = StFetch;
                    end
                end else if (mem_ready) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                RFWr    = 1'b1;
                PCWr    = 1'b1;
                state_d = StFetch;
                if (cls.addu || cls.subu) begin
                    WRSel = WR_RD;
                end else if (cls.lw) begin
                    WDSel = WD_MEM;
                end else if (cls.jal) begin
                    WRSel = WR_RA;
                    WDSel = WD_PC4;
                    jal   = 1'b1;
                end
            end
            StHalt: halted = 1'b1;
            default: state_d = StRst;
        endcase

        // ALU controls held from execute through write-back so results stay stable.
        if (state_q == StExe || state_q == StMem || state_q == StWb) begin
            if (cls.subu || cls.beq) begin
                ALUOP = ALU_SUB;
            end else if (cls.ori) begin
                ALUOP = ALU_OR;
            end else if (cls.lui) begin
                ALUOP = ALU_LUI;
            end else begin
                ALUOP = ALU_ADD;
            end
            BSel  = cls.ori | cls.lui | cls.lw | cls.sw;
            EXTOP = cls.lw | cls.sw;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StRst;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                op_q <= opcode;
                fn_q <= func;
                if (dec_illegal) begin
                    illegal_q <= 1'b1;
                end
            end
            if (PCWr) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign instr_done = PCWr;
    assign instr_cnt  = cnt_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. Stimulus pushes the expected
// retire-cycle controls; a monitor pops and compares on every instr_done.
module tb_mc_controller;

    typedef struct packed {
        logic [31:0] cnt;
        logic        rfwr;
        logic [1:0]  wrsel;
        logic [1:0]  wdsel;
        logic        beq;
        logic        jal;
        logic        jr;
        logic        dmwr;
        logic [2:0]  aluop;
        logic        bsel;
        logic        extop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = '0, func = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWr, IRWr, beq, jal, jr, EXTOP, BSel, RFWr, DMWr;
    logic [2:0]  ALUOP;
    logic [1:0]  WRSel, WDSel;
    logic        instr_done, illegal, halted;
    logic [31:0] instr_cnt;

    logic        reset2 = 1'b0;
    logic [5:0]  opcode2 = '0, func2 = '0;
    logic        PCWr2, IRWr2, beq2, jal2, jr2, EXTOP2, BSel2, RFWr2, DMWr2;
    logic [2:0]  ALUOP2;
    logic [1:0]  WRSel2, WDSel2;
    logic        instr_done2, illegal2, halted2;
    logic [2:0]  instr_cnt2;

    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mc_controller #(.CNT_W(32), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .beq(beq), .jal(jal), .jr(jr),
        .ALUOP(ALUOP), .EXTOP(EXTOP), .WRSel(WRSel), .BSel(BSel), .WDSel(WDSel),
        .RFWr(RFWr), .DMWr(DMWr), .instr_done(instr_done), .instr_cnt(instr_cnt),
        .illegal(illegal), .halted(halted)
    );

    mc_controller #(.CNT_W(3), .ILLEGAL_TRAP(1'b0)) dut2 (
        .clk(clk), .reset(reset2), .opcode(opcode2), .func(func2), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr2), .IRWr(IRWr2), .beq(beq2), .jal(jal2), .jr(jr2),
        .ALUOP(ALUOP2), .EXTOP(EXTOP2), .WRSel(WRSel2), .BSel(BSel2), .WDSel(WDSel2),
        .RFWr(RFWr2), .DMWr(DMWr2), .instr_done(instr_done2), .instr_cnt(instr_cnt2),
        .illegal(illegal2), .halted(halted2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic rfwr, input logic [1:0] wrsel,
                                input logic [1:0] wdsel, input logic b, input logic j,
                                input logic r, input logic dmwr, input logic [2:0] aluop,
                                input logic bsel, input logic extop);
        exp_t e;
        e.cnt   = '0;
        e.rfwr  = rfwr;
        e.wrsel = wrsel;
        e.wdsel = wdsel;
        e.beq   = b;
        e.jal   = j;
        e.jr    = r;
        e.dmwr  = dmwr;
        e.aluop = aluop;
        e.bsel  = bsel;
        e.extop = extop;
        return e;
    endfunction

    // Monitor: every retire must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset && instr_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_retire", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("retire_cnt", 64'(instr_cnt), 64'(mon_e.cnt));
                chk("retire_ctrl",
                    {PCWr, RFWr, WRSel, WDSel, beq, jal, jr, DMWr, ALUOP, BSel, EXTOP},
                    {1'b1, mon_e.rfwr, mon_e.wrsel, mon_e.wdsel, mon_e.beq, mon_e.jal,
                     mon_e.jr, mon_e.dmwr, mon_e.aluop, mon_e.bsel, mon_e.extop});
            end
        end
    end

    // Holds reset 3 cycles, releases; returns #1 into the first fetch cycle.
    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        opcode = '0;
        func = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {PCWr, IRWr, beq, jal, jr, ALUOP, EXTOP, WRSel, BSel, WDSel, RFWr, DMWr,
             instr_done, illegal, halted}, 0);
        chk("reset_cnt", instr_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = 0;
    endtask

    // Called #1 into a fetch cycle; runs one instruction to retirement.
    task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input int mem_wait, input bit mr_hi, input int exp_cyc,
                            input int exp_dmwr, input exp_t e);
        int c = 1;
        int pcw = 0, dmw = 0, bad = 0;
        bit done = 0;
        e.cnt = 32'(exp_cnt);
        sb_q.push_back(e);
        opcode = op;
        func = fn;
        while (!done && c <= 20) begin
            mem_ready = mr_hi || (c == 4 + mem_wait);
            @(negedge clk);
            if (IRWr !== (c == 1)) bad++;
            if (IRWr && PCWr) bad++;
            if (RFWr && !instr_done) bad++;
            if (PCWr) pcw++;
            if (DMWr) dmw++;
            if (instr_done) done = 1;
            @(posedge clk);
            #1;
            c++;
        end
        mem_ready = 1'b0;
        exp_cnt++;
        chk({name, "_cycles"}, c - 1, exp_cyc);
        chk({name, "_pcwr_once"}, pcw, 1);
        chk({name, "_dmwr_cycles"}, dmw, exp_dmwr);
        chk({name, "_seq"}, bad, 0);
        chk({name, "_cnt_after"}, instr_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        //       name    op         fn          wait hi cyc dmw  rfwr wrsel wdsel b j r dm alu bs ex
        do_instr("addu", 6'b000000, 6'b100001, 0, 0, 4, 0, mk(1, 2'b01, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        do_instr("subu", 6'b000000, 6'b100011, 0, 0, 4, 0, mk(1, 2'b01, 2'b00, 0, 0, 0, 0, 3'b001, 0, 0));
        do_instr("ori",  6'b001101, 6'b010101, 0, 0, 4, 0, mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 3'b010, 1, 0));
        do_instr("lui",  6'b001111, 6'b000000, 0, 0, 4, 0, mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 3'b011, 1, 0));
        do_instr("lw_w3", 6'b100011, 6'b000100, 3, 0, 8, 0, mk(1, 2'b00, 2'b01, 0, 0, 0, 0, 3'b000, 1, 1));
        do_instr("lw_w0", 6'b100011, 6'b000000, 0, 0, 5, 0, mk(1, 2'b00, 2'b01, 0, 0, 0, 0, 3'b000, 1, 1));
        do_instr("sw_w1", 6'b101011, 6'b000000, 1, 0, 5, 2, mk(0, 2'b00, 2'b00, 0, 0, 0, 1, 3'b000, 1, 1));
        do_instr("beq",  6'b000100, 6'b000000, 0, 0, 3, 0, mk(0, 2'b00, 2'b00, 1, 0, 0, 0, 3'b001, 0, 0));
        do_instr("jal",  6'b000011, 6'b000000, 0, 0, 3, 0, mk(1, 2'b10, 2'b10, 0, 1, 0, 0, 3'b000, 0, 0));
        do_instr("jr",   6'b000000, 6'b001000, 0, 0, 3, 0, mk(0, 2'b00, 2'b00, 0, 0, 1, 0, 3'b000, 0, 0));
        do_instr("nop",  6'b000000, 6'b000000, 0, 0, 2, 0, mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        // mem_ready held high outside the memory phase must not change anything
        do_instr("addu_mr", 6'b000000, 6'b100001, 0, 1, 4, 0, mk(1, 2'b01, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0));
        chk("sb_drain", sb_q.size(), 0);

        // sw aborted by reset while waiting on memory
        opcode = 6'b101011;
        func = 6'b000000;
        repeat (4) @(negedge clk);
        chk("sw_abort_dmwr_before", DMWr, 1);
        #1 reset = 1'b0;
        #1;
        chk("sw_abort_dmwr_pcwr", {DMWr, PCWr}, 0);
        chk("sw_abort_cnt", instr_cnt, 0);
        do_reset();

        // unsupported opcode with trapping enabled
        opcode = 6'b111111;
        func = 6'b000000;
        @(negedge clk);
        @(negedge clk);
        chk("ill_decode_pcwr", PCWr, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ill_halt_flags", {illegal, halted, IRWr, PCWr}, 4'b1100);
        chk("ill_halt_cnt", instr_cnt, 0);
        reset = 1'b0;
        #1;
        chk("ill_reset_clear", {illegal, halted}, 0);

        // second instance: unsupported retired as nop, counter wraps at 3 bits
        @(negedge clk);
        reset2 = 1'b1;
        @(posedge clk);
        #1;
        opcode2 = 6'b111111;
        @(negedge clk);
        @(negedge clk);
        chk("ill2_retire", {instr_done2, PCWr2, halted2}, 3'b110);
        @(posedge clk);
        #1;
        chk("ill2_flag_cnt", {illegal2, instr_cnt2}, {1'b1, 3'd1});
        opcode2 = 6'b000000;
        func2 = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) chk("cnt2_max", instr_cnt2, 7);
            @(negedge clk);
            @(negedge clk);
            if (i == 6) chk("nop2_done", instr_done2, 1);
            @(posedge clk);
            #1;
        end
        chk("cnt2_wrap", instr_cnt2, 0);
        @(negedge clk);
        chk("done2_pulse", instr_done2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
